// File: rtl/mem32_stream_reader_if.sv
// mem32_stream_reader_if
// Purpose : groups the tagged mem32 request/acknowledge bus and the output
//           valid/ready stream of the mem32 stream reader.
// Signals : mem32_request/address/direction/byte_en/wdata/tag  initiator -> responder
//           mem32_rack/rack_tag/dack_tag/rdata                 responder -> initiator
//           out_data/out_valid                                 reader -> consumer
//           out_ready                                          consumer -> reader
// Modports: master = reader side, slave = responder/consumer side.
interface mem32_stream_reader_if;
  logic        mem32_request;
  logic [25:0] mem32_address;
  logic        mem32_direction;
  logic [3:0]  mem32_byte_en;
  logic [31:0] mem32_wdata;
  logic [7:0]  mem32_tag;
  logic        mem32_rack;
  logic [7:0]  mem32_rack_tag;
  logic [7:0]  mem32_dack_tag;
  logic [31:0] mem32_rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem32_request, mem32_address, mem32_direction, mem32_byte_en,
    output mem32_wdata, mem32_tag, out_data, out_valid,
    input  mem32_rack, mem32_rack_tag, mem32_dack_tag, mem32_rdata, out_ready
  );

  modport slave (
    input  mem32_request, mem32_address, mem32_direction, mem32_byte_en,
    input  mem32_wdata, mem32_tag, out_data, out_valid,
    output mem32_rack, mem32_rack_tag, mem32_dack_tag, mem32_rdata, out_ready
  );
endinterface

// File: rtl/mem32_stream_reader.sv
// mem32_stream_reader
// Purpose : on a start pulse, reads word_count contiguous 32-bit words from
//           DDR over the tagged mem32 port, buffers them in a 2^FIFO_LOG2
//           word FIFO and presents them on a valid/ready stream.
// Ports   : clock, reset (async, active-high)
//           start, start_addr[25:0], word_count[15:0]  transfer control
//           busy, done                                  transfer status
//           bus (mem32_stream_reader_if.master)         mem32 bus + stream
// Params  : TAG (non-zero request tag), FIFO_LOG2 (FIFO depth log2, >= 1)
// Macro   : MEM32_READER_BYTE_SWAP_EN byte-reverses each word on FIFO entry.
module mem32_stream_reader #(
  parameter logic [7:0]  TAG       = 8'hA5,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] start_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  mem32_stream_reader_if.master bus
);

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 16;
  localparam int unsigned PW    = FIFO_LOG2;
  localparam int unsigned CW    = FIFO_LOG2 + 1;
  localparam int unsigned SW    = FIFO_LOG2 + 2;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] req_left_q, req_left_d;
  logic [LW-1:0] data_left_q, data_left_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] head_q, head_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [SW-1:0] credit_used;

  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic          ret;
  logic          pop;
  logic          final_pop;
  logic [DW-1:0] wdata_in;

  // Handshake qualifiers: only our own tag counts, late data after reset is dropped.
  assign accept    = req_q & bus.mem32_rack & (bus.mem32_rack_tag == TAG);
  assign ret       = (bus.mem32_dack_tag == TAG) & (state_q != IDLE) & (outstanding_q != '0);
  assign pop       = valid_q & bus.out_ready;
  assign final_pop = pop & (state_q != IDLE) & (fifo_count_q == CW'(1)) & (data_left_q == '0);

`ifdef MEM32_READER_BYTE_SWAP_EN
  assign wdata_in = {bus.mem32_rdata[7:0], bus.mem32_rdata[15:8],
                     bus.mem32_rdata[23:16], bus.mem32_rdata[31:24]};
`else
  assign wdata_in = bus.mem32_rdata;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    addr_d        = addr_q;
    req_left_d    = req_left_q;
    data_left_d   = data_left_q;
    outstanding_d = outstanding_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    head_d        = head_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    credit_used   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d     = ISSUE;
            addr_d      = start_addr & ~AW'(3);
            req_left_d  = word_count;
            data_left_d = word_count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept && (req_left_q == LW'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (final_pop || ((data_left_q == '0) && (fifo_count_q == '0))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      addr_d     = addr_q + AW'(4);
      req_left_d = req_left_q - LW'(1);
    end
    if (ret) data_left_d = data_left_q - LW'(1);
    outstanding_d = outstanding_q + CW'(accept) - CW'(ret);
    fifo_count_d  = fifo_count_q + CW'(ret) - CW'(pop);
    if (ret) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // Head register mirrors mem[rd_ptr]; bypass the write when the FIFO is (about to be) empty.
    if (pop) begin
      if (fifo_count_q == CW'(1)) begin
        if (ret) head_d = wdata_in;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end else if ((fifo_count_q == '0) && ret) begin
      head_d = wdata_in;
    end
    valid_d = (fifo_count_d != '0);

    // A raised request is held until accepted; a new one needs a free FIFO slot.
    credit_used = SW'(fifo_count_d) + SW'(outstanding_d);
    if (req_q && !accept) begin
      req_d = 1'b1;
    end else begin
      req_d = (state_d == ISSUE) && (req_left_d != '0) && (credit_used < DEPTH_S);
    end

    if (final_pop) done_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      addr_q        <= '0;
      req_left_q    <= '0;
      data_left_q   <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      head_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      req_left_q    <= req_left_d;
      data_left_q   <= data_left_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      head_q        <= head_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (ret) mem[wr_ptr_q] <= wdata_in;
  end

  assign bus.mem32_request   = req_q;
  assign bus.mem32_address   = addr_q;
  assign bus.mem32_direction = 1'b0;
  assign bus.mem32_byte_en   = 4'hF;
  assign bus.mem32_wdata     = '0;
  assign bus.mem32_tag       = TAG;
  assign bus.out_data        = head_q;
  assign bus.out_valid       = valid_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_mem32_stream_reader.sv
// tb_mem32_stream_reader
// Purpose : self-checking bench for mem32_stream_reader with a tagged mem32
//           responder model, a stream consumer and an expected-word queue.
// Ports   : none (top level); DUT connected through mem32_stream_reader_if.
// Macro   : MEM32_READER_BYTE_SWAP_EN selects the byte-reversed expectation.
module tb_mem32_stream_reader;

  localparam logic [7:0] TAG     = 8'hA5;
  localparam logic [7:0] BAD_TAG = 8'h3C;

  logic        clk;
  logic        rst;
  logic        start;
  logic [25:0] start_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;

  mem32_stream_reader_if bus();

  mem32_stream_reader #(.TAG(TAG), .FIFO_LOG2(3)) dut (
    .clock      (clk),
    .reset      (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } ret_t;

  typedef struct {
    logic [25:0] addr;
    logic [15:0] wc;
    logic [31:0] seed;
    int          lat;
    int          ready_mode;
    bit          inject;
    int          exp_reqs;
    int          exp_done;
  } vec_t;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int lat        = 1;
  int ready_mode = 1;
  int ack_limit  = 1000;
  int acc_cnt    = 0;
  int done_cnt   = 0;
  int words_rx   = 0;
  bit inject     = 1'b0;

  logic [25:0] exp_addr_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] sb[$];
  ret_t        pending[$];
  vec_t        vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_out(input logic [31:0] d);
`ifdef MEM32_READER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder: acks requests within the same cycle, returns data lat cycles later.
  initial begin
    bus.mem32_rack     = 1'b0;
    bus.mem32_rack_tag = 8'h00;
    bus.mem32_dack_tag = 8'h00;
    bus.mem32_rdata    = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem32_rack     = 1'b0;
      bus.mem32_rack_tag = 8'h00;
      bus.mem32_dack_tag = 8'h00;
      bus.mem32_rdata    = 32'h0;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
        bus.mem32_dack_tag = TAG;
        bus.mem32_rdata    = pending[0].data;
        pending.delete(0);
      end else if (inject && (cyc % 3 == 0)) begin
        bus.mem32_dack_tag = BAD_TAG;
        bus.mem32_rdata    = 32'hDEADBEEF;
      end
      if (bus.mem32_request) begin
        if (inject && (cyc % 2 == 0)) begin
          bus.mem32_rack     = 1'b1;
          bus.mem32_rack_tag = BAD_TAG;
        end else if (acc_cnt < ack_limit) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_request: got address %h, expected no request", bus.mem32_address);
          end else begin
            bus.mem32_rack     = 1'b1;
            bus.mem32_rack_tag = TAG;
            check("req_addr", 32'(bus.mem32_address), 32'(exp_addr_q.pop_front()));
            pending.push_back('{resp_q.pop_front(), cyc + lat});
            acc_cnt++;
          end
        end
      end
    end
  end

  // Consumer: applies out_ready policy, scores popped words and done pulses.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done) begin
        done_cnt++;
        check("busy_low_with_done", 32'(busy), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", bus.out_data);
        end else begin
          check("stream_word", bus.out_data, sb.pop_front());
          words_rx++;
        end
      end
    end
  end

  task automatic prep(input logic [25:0] addr, input logic [15:0] wc, input logic [31:0] seed);
    logic [25:0] base;
    logic [31:0] d;
    acc_cnt  = 0;
    done_cnt = 0;
    words_rx = 0;
    base = {addr[25:2], 2'b00};
    for (int i = 0; i < int'(wc); i++) begin
      d = seed + 32'h11111111 * 32'(i);
      exp_addr_q.push_back(base + 26'(4 * i));
      resp_q.push_back(d);
      sb.push_back(exp_out(d));
    end
  endtask

  task automatic pulse_start(input logic [25:0] addr, input logic [15:0] wc);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) check({name, "_timeout"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input vec_t v);
    lat        = v.lat;
    ready_mode = v.ready_mode;
    inject     = v.inject;
    ack_limit  = 1000;
    prep(v.addr, v.wc, v.seed);
    pulse_start(v.addr, v.wc);
    if (v.wc != 16'd0) begin
      check("busy_at_cycle1", 32'(busy), 32'd1);
      check("req_at_cycle1", 32'(bus.mem32_request), 32'd1);
    end else begin
      check("done_at_cycle1", 32'(done), 32'd1);
      check("req_zero_len", 32'(bus.mem32_request), 32'd0);
    end
    wait_done("xfer", 200 + 10 * int'(v.wc) + v.lat);
    inject = 1'b0;
    check("done_pulses", 32'(done_cnt), 32'(v.exp_done));
    check("requests", 32'(acc_cnt), 32'(v.exp_reqs));
    check("words", 32'(words_rx), 32'(v.wc));
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(bus.out_valid), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;

    vecs[0] = '{26'h0000100, 16'd4,  32'h11111111, 3, 1, 1'b0, 4,  1};
    vecs[1] = '{26'h3FFFFFC, 16'd2,  32'h01020304, 1, 1, 1'b0, 2,  1};
    vecs[2] = '{26'h0002000, 16'd9,  32'hA0A0A0A0, 4, 1, 1'b1, 9,  1};
    vecs[3] = '{26'h0000007, 16'd3,  32'hCAFE0000, 2, 2, 1'b0, 3,  1};
    vecs[4] = '{26'h0000040, 16'd0,  32'h00000000, 1, 1, 1'b0, 0,  1};
    vecs[5] = '{26'h0123456, 16'd16, 32'h00000001, 6, 2, 1'b0, 16, 1};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_request", 32'(bus.mem32_request), 32'd0);
    check("rst_address", 32'(bus.mem32_address), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("const_direction", 32'(bus.mem32_direction), 32'd0);
    check("const_byte_en", 32'(bus.mem32_byte_en), 32'hF);
    check("const_wdata", bus.mem32_wdata, 32'd0);
    check("const_tag", 32'(bus.mem32_tag), 32'hA5);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_xfer(vecs[k]);

    // Second start while busy must be ignored.
    lat = 2; ready_mode = 1; inject = 1'b0; ack_limit = 1000;
    prep(26'h0000500, 16'd6, 32'h55550000);
    pulse_start(26'h0000500, 16'd6);
    @(negedge clk);
    pulse_start(26'h0009000, 16'd5);
    wait_done("busy_start", 300);
    check("bs_requests", 32'(acc_cnt), 32'd6);
    check("bs_words", 32'(words_rx), 32'd6);
    check("bs_done", 32'(done_cnt), 32'd1);

    // Back-pressure: credit limits outstanding+buffered words to the FIFO depth.
    lat = 2; ready_mode = 0;
    prep(26'h0000800, 16'd20, 32'h76540000);
    pulse_start(26'h0000800, 16'd20);
    repeat (40) @(negedge clk);
    check("bp_requests_stalled", 32'(acc_cnt), 32'd8);
    check("bp_request_low", 32'(bus.mem32_request), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_words_none", 32'(words_rx), 32'd0);
    ready_mode = 1;
    wait_done("backpressure", 400);
    check("bp_requests", 32'(acc_cnt), 32'd20);
    check("bp_words", 32'(words_rx), 32'd20);
    check("bp_done", 32'(done_cnt), 32'd1);

    // Reset mid-transfer with two reads still in flight.
    lat = 10; ready_mode = 1; ack_limit = 2;
    prep(26'h0000A00, 16'd6, 32'h99990000);
    pulse_start(26'h0000A00, 16'd6);
    for (int i = 0; i < 30 && acc_cnt < 2; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_request", 32'(bus.mem32_request), 32'd0);
    check("mid_rst_address", 32'(bus.mem32_address), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    resp_q.delete();
    sb.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("late_ret_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("late_ret_busy", 32'(busy), 32'd0);
    check("late_ret_delivered", 32'(pending.size()), 32'd0);
    check("late_ret_no_done", 32'(done_cnt), 32'd0);
    ack_limit = 1000;

    // Recovery after the aborted transfer.
    run_xfer(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
